// File: rtl/ml_qspi_master.sv
// ml_qspi_master
// Byte-stream QSPI master for the MARLANN coprocessor link. The bus bridge
// upstream hands over one command byte at a time. Each byte is transmitted or
// received as two nibbles, high nibble first, in SPI mode 0: the slave samples
// on rising ml_clk, and data changes on falling ml_clk. ml_csb stays low across
// bytes until a byte flagged cmd_last completes. After that, ml_csb is held
// high for CSB_HOLD cycles.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (see below)
//   cmd_data              byte to transmit (ignored for reads)
//   cmd_read              1 = receive a byte, 0 = transmit cmd_data
//   cmd_last              release ml_csb after this byte
//   rsp_valid             one-cycle pulse when a received byte is available
//   rsp_data              received byte, held until the next rsp_valid
//   busy                  high whenever the FSM is not IDLE
//   ml_clk, ml_csb        QSPI clock and active-low chip select
//   ml_io_do/oe/di        QSPI data out, per-bit output enable, data in
//
// Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready.
// cmd_ready depends only on state and reset, never on cmd_valid. The cmd_*
// fields are sampled only on that edge. The response side has no backpressure.
module ml_qspi_master #(
    parameter int CLKDIV   = 1,
    parameter int DUMMY    = 2,
    parameter int CSB_HOLD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_read,
    input  logic       cmd_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       ml_clk,
    output logic       ml_csb,
    output logic [3:0] ml_io_do,
    output logic [3:0] ml_io_oe,
    input  logic [3:0] ml_io_di
);

    localparam int DIV_W       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int TURN_HALVES = (DUMMY > 0) ? 2 * DUMMY : 1;
    localparam int HALF_MAX    = (TURN_HALVES > 4) ? TURN_HALVES : 4;
    localparam int HALF_W      = $clog2(HALF_MAX);
    localparam int HOLD_W      = (CSB_HOLD > 1) ? $clog2(CSB_HOLD) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKDIV - 1);
    localparam logic [HALF_W-1:0] HALF_0    = HALF_W'(0);
    localparam logic [HALF_W-1:0] HALF_1    = HALF_W'(1);
    localparam logic [HALF_W-1:0] HALF_2    = HALF_W'(2);
    localparam logic [HALF_W-1:0] HALF_3    = HALF_W'(3);
    localparam logic [HALF_W-1:0] TURN_LAST = HALF_W'(TURN_HALVES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((CSB_HOLD > 0) ? CSB_HOLD - 1 : 0);

    typedef enum logic [2:0] {IDLE, SHIFT, TURN, WAIT, HOLD} state_t;

    // state_q is the observation point for the FSM.
    state_t state_q, state_d;

    logic [DIV_W-1:0]  div_q;      // clk count within one ml_clk half-period
    logic [HALF_W-1:0] half_q;     // half-period index within SHIFT or TURN
    logic [HOLD_W-1:0] hold_q;     // cycles spent in HOLD
    logic              read_q;
    logic              last_q;
    logic              prev_write_q;
    logic [3:0]        tx_lo_q;
    logic [3:0]        rx_hi_q;
    logic [3:0]        rx_lo_q;
    logic [3:0]        do_q;
    logic [3:0]        oe_q;
    logic              rsp_valid_q;
    logic [7:0]        rsp_data_q;

    logic tick;
    logic accept;
    logic need_turn;
    logic shift_done;
    logic turn_done;
    logic hold_done;

    always_comb begin
        tick       = (div_q == DIV_LAST);
        shift_done = (state_q == SHIFT) && tick && (half_q == HALF_3);
        turn_done  = (state_q == TURN) && tick && (half_q == TURN_LAST);
        hold_done  = (state_q == HOLD) && (hold_q == HOLD_LAST);
        cmd_ready  = !reset && ((state_q == IDLE) || (state_q == WAIT));
        accept     = cmd_valid && cmd_ready;
        // A turnaround is only needed when the previous byte of the same
        // transaction was a write. Only WAIT can be mid-transaction.
        need_turn  = (DUMMY > 0) && (state_q == WAIT) && cmd_read && prev_write_q;
        busy       = (state_q != IDLE);
        ml_csb     = (state_q == IDLE) || (state_q == HOLD);
        // Odd half-periods are the high phase of ml_clk.
        ml_clk     = ((state_q == SHIFT) || (state_q == TURN)) && half_q[0];
        ml_io_do   = do_q;
        ml_io_oe   = oe_q;
        rsp_valid  = rsp_valid_q;
        rsp_data   = rsp_data_q;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WAIT: begin
                if (accept) begin
                    state_d = need_turn ? TURN : SHIFT;
                end
            end
            TURN: begin
                if (turn_done) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_done) begin
                    if (!last_q) begin
                        state_d = WAIT;
                    end else if (CSB_HOLD > 0) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (hold_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: divider, nibble shifting, capture and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= '0;
            half_q       <= '0;
            hold_q       <= '0;
            read_q       <= 1'b0;
            last_q       <= 1'b0;
            prev_write_q <= 1'b0;
            tx_lo_q      <= '0;
            rx_hi_q      <= '0;
            rx_lo_q      <= '0;
            do_q         <= '0;
            oe_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                div_q  <= '0;
                half_q <= '0;
                read_q <= cmd_read;
                last_q <= cmd_last;
                if (cmd_read) begin
                    oe_q <= 4'h0;
                end else begin
                    // The high nibble is on the bus in the first cycle of the byte.
                    oe_q    <= 4'hF;
                    do_q    <= cmd_data[7:4];
                    tx_lo_q <= cmd_data[3:0];
                end
            end else if ((state_q == SHIFT) || (state_q == TURN)) begin
                if (!tick) begin
                    div_q <= div_q + 1'b1;
                end else begin
                    div_q <= '0;
                    if (shift_done || turn_done) begin
                        half_q <= '0;
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                    if (state_q == SHIFT) begin
                        // Capture on the edge that raises ml_clk, which is the
                        // same instant the slave samples our data.
                        if ((half_q == HALF_0) && read_q) begin
                            rx_hi_q <= ml_io_di;
                        end
                        // The low nibble changes on the edge that drops ml_clk.
                        if ((half_q == HALF_1) && !read_q) begin
                            do_q <= tx_lo_q;
                        end
                        if ((half_q == HALF_2) && read_q) begin
                            rx_lo_q <= ml_io_di;
                        end
                        if (shift_done) begin
                            prev_write_q <= !read_q;
                            hold_q       <= '0;
                            if (read_q) begin
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= {rx_hi_q, rx_lo_q};
                            end
                            if (last_q) begin
                                oe_q <= 4'h0;
                            end
                        end
                    end
                end
            end else if (state_q == HOLD) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ml_qspi_master.sv
// Testbench for ml_qspi_master.
// u_dut runs with CLKDIV=1 and goes through a vector table, a random stream,
// and a reset-in-flight sequence. u_dut3 runs with CLKDIV=3 and goes through
// the back-to-back write sequence. Expected read bytes are queued at
// acceptance and compared against rsp_data when rsp_valid pulses.
module tb_ml_qspi_master;

    localparam int HOLD_CYC = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       read;
        logic       last;
        logic [3:0] di_hi;
        logic [3:0] di_lo;
        logic       turn;
        logic [7:0] exp_rsp;
    } vec_t;

    // Clock and reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // u_dut signals (CLKDIV = 1)
    logic       cmd_valid, cmd_read, cmd_last, cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid, busy, ml_clk, ml_csb;
    logic [7:0] rsp_data;
    logic [3:0] ml_io_do, ml_io_oe, ml_io_di;

    // u_dut3 signals (CLKDIV = 3)
    logic       cmd_valid3, cmd_read3, cmd_last3, cmd_ready3;
    logic [7:0] cmd_data3;
    logic       rsp_valid3, busy3, ml_clk3, ml_csb3;
    logic [7:0] rsp_data3;
    logic [3:0] ml_io_do3, ml_io_oe3, ml_io_di3;

    ml_qspi_master #(.CLKDIV(1), .DUMMY(2), .CSB_HOLD(HOLD_CYC)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_read(cmd_read), .cmd_last(cmd_last),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .ml_clk(ml_clk), .ml_csb(ml_csb),
        .ml_io_do(ml_io_do), .ml_io_oe(ml_io_oe), .ml_io_di(ml_io_di)
    );

    ml_qspi_master #(.CLKDIV(3), .DUMMY(2), .CSB_HOLD(HOLD_CYC)) u_dut3 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_data(cmd_data3),
        .cmd_read(cmd_read3), .cmd_last(cmd_last3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3),
        .ml_clk(ml_clk3), .ml_csb(ml_csb3),
        .ml_io_do(ml_io_do3), .ml_io_oe(ml_io_oe3), .ml_io_di(ml_io_di3)
    );

    // Scoreboard
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (!reset && rsp_valid3) begin
            check("rsp3_unexpected", 32'd1, 32'd0);
        end
    end

    // Driver: one byte on u_dut with full waveform checks. It is called just
    // after a negedge. After acceptance, cmd_valid stays high with
    // inverted fields to show that nothing is accepted or re-sampled while
    // the block is busy.
    task automatic do_byte(input vec_t v);
        int budget;
        cmd_valid = 1'b1;
        cmd_data  = v.data;
        cmd_read  = v.read;
        cmd_last  = v.last;
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        if (v.read) exp_q.push_back(v.exp_rsp);
        @(posedge clk);
        #1;
        cmd_data = ~v.data;
        cmd_read = ~v.read;
        cmd_last = ~v.last;
        if (v.turn) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("turn_oe", {28'd0, ml_io_oe}, 32'h0);
                check("turn_clk", {31'd0, ml_clk}, i % 2);
                check("turn_csb", {31'd0, ml_csb}, 32'd0);
                check("turn_ready", {31'd0, cmd_ready}, 32'd0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (v.read) begin
                // The real nibble is driven only in the cycle that ends with
                // the rising-clock capture edge. Decoys are driven elsewhere.
                case (i)
                    0: ml_io_di = v.di_hi;
                    1: ml_io_di = ~v.di_hi;
                    2: ml_io_di = v.di_lo;
                    default: ml_io_di = ~v.di_lo;
                endcase
                check("shift_oe_rd", {28'd0, ml_io_oe}, 32'h0);
            end else begin
                check("shift_oe_wr", {28'd0, ml_io_oe}, 32'hF);
                check("shift_do", {28'd0, ml_io_do}, (i < 2) ? {28'd0, v.data[7:4]} : {28'd0, v.data[3:0]});
            end
            check("shift_clk", {31'd0, ml_clk}, i % 2);
            check("shift_csb", {31'd0, ml_csb}, 32'd0);
            check("shift_ready", {31'd0, cmd_ready}, 32'd0);
            check("shift_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        if (v.last) begin
            for (int i = 0; i < HOLD_CYC; i++) begin
                if (i > 0) @(negedge clk);
                check("hold_csb", {31'd0, ml_csb}, 32'd1);
                check("hold_oe", {28'd0, ml_io_oe}, 32'h0);
                check("hold_busy", {31'd0, busy}, 32'd1);
                check("hold_ready", {31'd0, cmd_ready}, 32'd0);
            end
            @(negedge clk);
            check("idle_ready", {31'd0, cmd_ready}, 32'd1);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_csb", {31'd0, ml_csb}, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            check("wait_csb", {31'd0, ml_csb}, 32'd0);
            check("wait_clk", {31'd0, ml_clk}, 32'd0);
            check("wait_ready", {31'd0, cmd_ready}, 32'd1);
            check("wait_oe", {28'd0, ml_io_oe}, v.read ? 32'h0 : 32'hF);
        end
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[8];
    vec_t v;
    logic txn_open, prev_write;

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[1] = '{8'h9F, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 4'h3, 4'hC, 1'b1, 8'h3C};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 4'h5, 4'hA, 1'b0, 8'h5A};
        tbl[4] = '{8'h66, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[5] = '{8'h00, 1'b1, 1'b0, 4'hE, 4'h1, 1'b1, 8'hE1};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 4'h0, 4'h7, 1'b0, 8'h07};
        tbl[7] = '{8'h00, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00};

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_data = 8'h00; cmd_read = 1'b0; cmd_last = 1'b0;
        ml_io_di = 4'h0;
        cmd_valid3 = 1'b0; cmd_data3 = 8'h00; cmd_read3 = 1'b0; cmd_last3 = 1'b0;
        ml_io_di3 = 4'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_csb", {31'd0, ml_csb}, 32'd1);
        check("rst_clk", {31'd0, ml_clk}, 32'd0);
        check("rst_oe", {28'd0, ml_io_oe}, 32'h0);
        check("rst_do", {28'd0, ml_io_do}, 32'h0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", {24'd0, rsp_data}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_ready3", {31'd0, cmd_ready3}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // Vector table
        for (int k = 0; k < 8; k++) begin
            do_byte(tbl[k]);
        end

        // Random stream with a small turnaround model
        txn_open = 1'b0;
        prev_write = 1'b0;
        for (int k = 0; k < 10; k++) begin
            v.read    = 1'($urandom_range(0, 1));
            v.data    = 8'($urandom_range(0, 255));
            v.last    = (k == 9) || ($urandom_range(0, 2) == 0);
            v.di_hi   = 4'($urandom_range(0, 15));
            v.di_lo   = 4'($urandom_range(0, 15));
            v.turn    = txn_open && v.read && prev_write;
            v.exp_rsp = {v.di_hi, v.di_lo};
            do_byte(v);
            txn_open   = !v.last;
            prev_write = !v.read;
        end

        // Reset in the middle of a read byte: no response, clean restart
        cmd_valid = 1'b1; cmd_data = 8'hC3; cmd_read = 1'b1; cmd_last = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_csb_low", {31'd0, ml_csb}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_csb", {31'd0, ml_csb}, 32'd1);
        check("mid_rst_clk", {31'd0, ml_clk}, 32'd0);
        check("mid_rst_oe", {28'd0, ml_io_oe}, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rsp_quiet", {31'd0, rsp_valid}, 32'd0);
        v = '{8'h5A, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00};
        do_byte(v);

        // CLKDIV=3: back-to-back writes with cmd_valid held high throughout
        cmd_valid3 = 1'b1; cmd_data3 = 8'h12; cmd_read3 = 1'b0; cmd_last3 = 1'b0;
        @(posedge clk);
        #1;
        cmd_data3 = 8'h34; cmd_last3 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("d3_b1_clk", {31'd0, ml_clk3}, ((i - 1) / 3) % 2);
            check("d3_b1_do", {28'd0, ml_io_do3}, (i <= 6) ? 32'h1 : 32'h2);
            check("d3_b1_csb", {31'd0, ml_csb3}, 32'd0);
            check("d3_b1_ready", {31'd0, cmd_ready3}, 32'd0);
            check("d3_b1_oe", {28'd0, ml_io_oe3}, 32'hF);
        end
        @(negedge clk);
        check("d3_ready_13", {31'd0, cmd_ready3}, 32'd1);
        check("d3_csb_13", {31'd0, ml_csb3}, 32'd0);
        check("d3_clk_13", {31'd0, ml_clk3}, 32'd0);
        @(posedge clk);
        #1;
        cmd_data3 = 8'hFF; cmd_last3 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("d3_b2_clk", {31'd0, ml_clk3}, ((i - 1) / 3) % 2);
            check("d3_b2_do", {28'd0, ml_io_do3}, (i <= 6) ? 32'h3 : 32'h4);
            check("d3_b2_csb", {31'd0, ml_csb3}, 32'd0);
            check("d3_b2_ready", {31'd0, cmd_ready3}, 32'd0);
        end
        for (int i = 0; i < HOLD_CYC; i++) begin
            @(negedge clk);
            check("d3_hold_csb", {31'd0, ml_csb3}, 32'd1);
            check("d3_hold_ready", {31'd0, cmd_ready3}, 32'd0);
            check("d3_hold_oe", {28'd0, ml_io_oe3}, 32'h0);
        end
        @(negedge clk);
        check("d3_idle_ready", {31'd0, cmd_ready3}, 32'd1);
        check("d3_idle_busy", {31'd0, busy3}, 32'd0);
        cmd_valid3 = 1'b0;

        // Report
        repeat (3) @(negedge clk);
        check("rsp_outstanding", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
